// File: rtl/bcd_rtc_clock.sv
// ---------------------------------------------------------------------------
// bcd_rtc_clock
//
// Purpose:
//   Packed-BCD real-time clock that counts hours (kept internally in 24-hour
//   form), minutes and seconds. A built-in prescaler turns CLK_DIV enabled
//   clocks into one second. The hour display is mapped to 12-hour (with pm)
//   or 24-hour form at runtime. A validated load port sets the time.
//
// Optional feature (macro ALARM_EN):
//   Adds an armable alarm compared against hh:mm:00 of the running time.
//
// Parameters:
//   CLK_DIV  enabled clk cycles per second (1..2^24)
//   DIV_W    prescaler width, CLK_DIV <= 2^DIV_W
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   ena        count enable for the prescaler
//   mode24     1 = 24-hour display, 0 = 12-hour display with pm
//   load       single-cycle time-load strobe
//   load_hh/mm/ss  BCD time to load (hour in 24-hour form)
//   alarm_set, alarm_hh, alarm_mm, alarm_clr, alarm   (ALARM_EN only)
//   load_err   one-cycle pulse when a load or alarm_set value is rejected
//   sec_tick   one-cycle pulse coinciding with each new seconds value
//   pm         high when the internal hour is 12 or later
//   hh, mm, ss BCD display outputs
// ---------------------------------------------------------------------------
module bcd_rtc_clock #(
    parameter int CLK_DIV = 1,
    parameter int DIV_W   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode24,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
`ifdef ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_clr,
    output logic       alarm,
`endif
    output logic       load_err,
    output logic       sec_tick,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    // Both nibbles must be decimal digits and the value must not exceed lim.
    // Since legal BCD orders the same way as binary, a plain compare works.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
    endfunction

    // BCD increment wrapping from lim back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [7:0]       hour24_q, hour24_d;
    logic [7:0]       mm_q, mm_d;
    logic [7:0]       ss_q, ss_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sec_tick_q, sec_tick_d;
    logic             load_err_q, load_err_d;
    logic             tick;
    logic             load_ok;

`ifdef ALARM_EN
    logic [7:0] alarm_hh_q, alarm_hh_d;
    logic [7:0] alarm_mm_q, alarm_mm_d;
    logic       armed_q, armed_d;
    logic       alarm_q, alarm_d;
    logic       alarm_ok;
    logic       time_upd;
    logic       match;
    logic       rollover;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        hour24_d   = hour24_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        div_cnt_d  = div_cnt_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;

        // A load of either outcome blocks the prescaler for that cycle, so a
        // coinciding tick is simply lost.
        tick    = ena && !load && (div_cnt_q == DIV_MAX);
        load_ok = bcd_ok(load_hh, 8'h23) && bcd_ok(load_mm, 8'h59) && bcd_ok(load_ss, 8'h59);

        if (load) begin
            if (load_ok) begin
                hour24_d  = load_hh;
                mm_d      = load_mm;
                ss_d      = load_ss;
                div_cnt_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (ena) begin
            if (tick) begin
                div_cnt_d  = '0;
                sec_tick_d = 1'b1;
                ss_d       = bcd_inc(ss_q, 8'h59);
                if (ss_q == 8'h59) begin
                    mm_d = bcd_inc(mm_q, 8'h59);
                    if (mm_q == 8'h59)
                        hour24_d = bcd_inc(hour24_q, 8'h23);
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

`ifdef ALARM_EN
        alarm_hh_d = alarm_hh_q;
        alarm_mm_d = alarm_mm_q;
        armed_d    = armed_q;
        alarm_ok   = bcd_ok(alarm_hh, 8'h23) && bcd_ok(alarm_mm, 8'h59);

        if (alarm_set) begin
            if (alarm_ok) begin
                alarm_hh_d = alarm_hh;
                alarm_mm_d = alarm_mm;
                armed_d    = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end

        // Match is judged on the time about to be registered, so alarm rises
        // together with the matching display value.
        time_upd = (load && load_ok) || tick;
        match    = armed_q && time_upd && (hour24_d == alarm_hh_q) &&
                   (mm_d == alarm_mm_q) && (ss_d == 8'h00);
        rollover = tick && (ss_q == 8'h59);

        if (alarm_clr)
            alarm_d = 1'b0;
        else if (match)
            alarm_d = 1'b1;
        else if (rollover)
            alarm_d = 1'b0;
        else
            alarm_d = alarm_q;
`endif
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: reset is synchronous and sampled only at the clock edge; all
    // state updates use non-blocking assignments so every flop sees the
    // pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hour24_q   <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            div_cnt_q  <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
`ifdef ALARM_EN
            alarm_hh_q <= 8'h00;
            alarm_mm_q <= 8'h00;
            armed_q    <= 1'b0;
            alarm_q    <= 1'b0;
`endif
        end else begin
            hour24_q   <= hour24_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            div_cnt_q  <= div_cnt_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
`ifdef ALARM_EN
            alarm_hh_q <= alarm_hh_d;
            alarm_mm_q <= alarm_mm_d;
            armed_q    <= armed_d;
            alarm_q    <= alarm_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Display mapping: purely combinational so a mode change shows at once
    // -----------------------------------------------------------------------
    logic [4:0] hour_bin;
    logic [4:0] hour12;

    always_comb begin
        hour_bin = (5'(hour24_q[7:4]) * 5'd10) + 5'(hour24_q[3:0]);
        hour12   = 5'd0;
        pm       = (hour24_q >= 8'h12);
        if (mode24) begin
            hh = hour24_q;
        end else if (hour_bin == 5'd0) begin
            hh = 8'h12;
        end else if (hour_bin <= 5'd12) begin
            hh = hour24_q;
        end else begin
            // 13..23 map to 01..11; re-encode the binary result as BCD.
            hour12 = hour_bin - 5'd12;
            hh     = (hour12 >= 5'd10) ? {4'd1, 4'(hour12 - 5'd10)} : {4'd0, 4'(hour12)};
        end
    end

    assign mm       = mm_q;
    assign ss       = ss_q;
    assign sec_tick = sec_tick_q;
    assign load_err = load_err_q;
`ifdef ALARM_EN
    assign alarm    = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// ---------------------------------------------------------------------------
// tb_bcd_rtc_clock
//
// Self-checking bench for bcd_rtc_clock with CLK_DIV = 4. The reference model
// keeps the time as a plain count of seconds since midnight and derives the
// BCD display from it with integer arithmetic. Directed scenarios cover the
// key cases; a randomized phase then mixes enables, loads, mode flips and
// resets. Alarm checks are compiled only when ALARM_EN is defined.
// ---------------------------------------------------------------------------
module tb_bcd_rtc_clock;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       mode24;
    logic       load;
    logic [7:0] load_hh, load_mm, load_ss;
    logic       load_err, sec_tick, pm;
    logic [7:0] hh, mm, ss;
`ifdef ALARM_EN
    logic       alarm_set, alarm_clr, alarm;
    logic [7:0] alarm_hh, alarm_mm;
`endif

    bcd_rtc_clock #(.CLK_DIV(CLK_DIV), .DIV_W(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .mode24   (mode24),
        .load     (load),
        .load_hh  (load_hh),
        .load_mm  (load_mm),
        .load_ss  (load_ss),
`ifdef ALARM_EN
        .alarm_set(alarm_set),
        .alarm_hh (alarm_hh),
        .alarm_mm (alarm_mm),
        .alarm_clr(alarm_clr),
        .alarm    (alarm),
`endif
        .load_err (load_err),
        .sec_tick (sec_tick),
        .pm       (pm),
        .hh       (hh),
        .mm       (mm),
        .ss       (ss)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_t   = 0;     // seconds since midnight
    int m_div = 0;
    bit m_tick = 0;
    bit m_err  = 0;
`ifdef ALARM_EN
    int m_alarm_at = 0; // alarm time in seconds since midnight
    bit m_armed = 0;
    bit m_alarm = 0;
`endif

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_valid(input logic [7:0] v, input int lim);
        return (v[7:4] <= 9) && (v[3:0] <= 9) && (bcd2int(v) <= lim);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic model_update();
        bit upd;
        bit tk;
        upd = 0;
        tk  = 0;
        if (!reset) begin
            m_t = 0; m_div = 0; m_tick = 0; m_err = 0;
`ifdef ALARM_EN
            m_alarm_at = 0; m_armed = 0; m_alarm = 0;
`endif
        end else begin
            m_tick = 0;
            m_err  = 0;
            if (load) begin
                if (bcd_valid(load_hh, 23) && bcd_valid(load_mm, 59) && bcd_valid(load_ss, 59)) begin
                    m_t   = bcd2int(load_hh) * 3600 + bcd2int(load_mm) * 60 + bcd2int(load_ss);
                    m_div = 0;
                    upd   = 1;
                end else begin
                    m_err = 1;
                end
            end else if (ena) begin
                if (m_div == CLK_DIV - 1) begin
                    m_div  = 0;
                    m_t    = (m_t + 1) % 86400;
                    m_tick = 1;
                    upd    = 1;
                    tk     = 1;
                end else begin
                    m_div++;
                end
            end
`ifdef ALARM_EN
            if (alarm_clr)
                m_alarm = 0;
            else if (m_armed && upd && (m_t == m_alarm_at))
                m_alarm = 1;
            else if (tk && (m_t % 60 == 0))
                m_alarm = 0;
            if (alarm_set) begin
                if (bcd_valid(alarm_hh, 23) && bcd_valid(alarm_mm, 59)) begin
                    m_alarm_at = bcd2int(alarm_hh) * 3600 + bcd2int(alarm_mm) * 60;
                    m_armed    = 1;
                end else begin
                    m_err = 1;
                end
            end
`endif
        end
    endtask

    task automatic compare_all();
        int h;
        int h12;
        h   = m_t / 3600;
        h12 = (h % 12 == 0) ? 12 : h % 12;
        check("hh",       32'(hh), 32'(mode24 ? int2bcd(h) : int2bcd(h12)));
        check("mm",       32'(mm), 32'(int2bcd((m_t / 60) % 60)));
        check("ss",       32'(ss), 32'(int2bcd(m_t % 60)));
        check("pm",       32'(pm), 32'(h >= 12));
        check("sec_tick", 32'(sec_tick), 32'(m_tick));
        check("load_err", 32'(load_err), 32'(m_err));
`ifdef ALARM_EN
        check("alarm",    32'(alarm), 32'(m_alarm));
`endif
    endtask

    // One clock: model follows the inputs present at the edge, outputs are
    // sampled 1 time unit later. Inputs are then changed away from the edge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        step();
        load = 1'b0;
    endtask

    // Step until sec_tick is seen, bounded; returns the number of steps taken.
    task automatic run_to_tick(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            step();
            n++;
            if (sec_tick) break;
        end
        if (!sec_tick) check({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    initial begin
        int n;
        reset = 1'b0; ena = 1'b0; mode24 = 1'b0; load = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
`ifdef ALARM_EN
        alarm_set = 1'b0; alarm_clr = 1'b0; alarm_hh = 8'h00; alarm_mm = 8'h00;
`endif
        #1;

        // 1: reset state and same-cycle mode change
        step(); step();
        check("t1_hh12", 32'(hh), 32'h12);
        check("t1_mm",   32'(mm), 32'h00);
        check("t1_ss",   32'(ss), 32'h00);
        check("t1_pm",   32'(pm), 32'h0);
        mode24 = 1'b1; #1;
        check("t1_hh24", 32'(hh), 32'h00);
        mode24 = 1'b0;
        reset = 1'b1;

        // 2: prescaler, freeze, resume
        ena = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t2_ss1",   32'(ss), 32'h01);
        check("t2_tick1", 32'(sec_tick), 32'h1);
        for (int i = 0; i < 4; i++) step();
        check("t2_ss2",   32'(ss), 32'h02);
        step(); step();
        ena = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t2_frozen", 32'(ss), 32'h02);
        ena = 1'b1;
        step();
        check("t2_no_tick", 32'(sec_tick), 32'h0);
        step();
        check("t2_resume", 32'(ss), 32'h03);
        check("t2_tick2",  32'(sec_tick), 32'h1);

        // 3: 12-hour rollovers
        do_load(8'h11, 8'h59, 8'h59);
        run_to_tick("t3a", n);
        check("t3_hh", 32'(hh), 32'h12);
        check("t3_mm", 32'(mm), 32'h00);
        check("t3_ss", 32'(ss), 32'h00);
        check("t3_pm", 32'(pm), 32'h1);
        do_load(8'h23, 8'h59, 8'h59);
        run_to_tick("t3b", n);
        check("t3_mid_hh12", 32'(hh), 32'h12);
        check("t3_mid_pm",   32'(pm), 32'h0);
        mode24 = 1'b1; #1;
        check("t3_mid_hh24", 32'(hh), 32'h00);
        mode24 = 1'b0;

        // 4: rejected loads, then a valid afternoon load
        do_load(8'h24, 8'h00, 8'h00);
        check("t4_err_hh", 32'(load_err), 32'h1);
        check("t4_keep_ss", 32'(ss), 32'h00);
        step();
        check("t4_err_pulse", 32'(load_err), 32'h0);
        do_load(8'h10, 8'h5A, 8'h00);
        check("t4_err_mm", 32'(load_err), 32'h1);
        check("t4_keep_hh", 32'(hh), 32'h12);
        do_load(8'h13, 8'h05, 8'h09);
        check("t4_hh", 32'(hh), 32'h01);
        check("t4_mm", 32'(mm), 32'h05);
        check("t4_ss", 32'(ss), 32'h09);
        check("t4_pm", 32'(pm), 32'h1);

        // 5: load on the exact tick cycle discards the tick
        step(); step(); step();
        do_load(8'h08, 8'h00, 8'h00);
        check("t5_hh", 32'(hh), 32'h08);
        check("t5_ss", 32'(ss), 32'h00);
        check("t5_no_tick", 32'(sec_tick), 32'h0);
        run_to_tick("t5", n);
        check("t5_latency", 32'(n), 32'(CLK_DIV));

`ifdef ALARM_EN
        // 6: alarm set, fire, clear, self-expiry at the next minute
        alarm_set = 1'b1; alarm_hh = 8'h25; alarm_mm = 8'h00;
        step();
        check("t6_bad_set", 32'(load_err), 32'h1);
        alarm_hh = 8'h07; alarm_mm = 8'h30;
        step();
        alarm_set = 1'b0;
        do_load(8'h07, 8'h29, 8'h59);
        run_to_tick("t6a", n);
        check("t6_fire", 32'(alarm), 32'h1);
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        check("t6_clr", 32'(alarm), 32'h0);
        do_load(8'h07, 8'h29, 8'h59);
        run_to_tick("t6b", n);
        check("t6_fire2", 32'(alarm), 32'h1);
        for (int i = 0; i < 59; i++) run_to_tick("t6c", n);
        check("t6_hold", 32'(alarm), 32'h1);
        run_to_tick("t6d", n);
        check("t6_expire_mm", 32'(mm), 32'h31);
        check("t6_expire", 32'(alarm), 32'h0);
`endif

        // Randomized phase: model comparisons every cycle
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) != 0);
            ena    = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) begin
                load_hh = int2bcd($urandom_range(0, 23));
                load_mm = int2bcd($urandom_range(57, 59));
                load_ss = int2bcd($urandom_range(50, 59));
            end else begin
                load_hh = 8'($urandom);
                load_mm = 8'($urandom);
                load_ss = 8'($urandom);
            end
`ifdef ALARM_EN
            alarm_set = ($urandom_range(0, 49) == 0);
            alarm_hh  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : load_hh;
            alarm_mm  = int2bcd($urandom_range(58, 59));
            alarm_clr = ($urandom_range(0, 99) == 0);
`endif
            step();
            if ($urandom_range(0, 15) == 0) begin
                mode24 = ~mode24;
                #1;
                compare_all();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_rtc_clock.md
Name: bcd_rtc_clock

Overview:
Parametrised successor to the 12-hour BCD wall clock. It counts hours, minutes and seconds in packed BCD and has a built-in prescaler, so one second spans CLK_DIV enabled clocks. It adds a runtime 12/24-hour display mode, a validated time-load port and an optional alarm. It sits between the system tick source and the display/host register block.

Parameters:
CLK_DIV, 1, number of enabled clk cycles per second (1..2^24); 1 means every enabled cycle is a second
DIV_W, 24, width of prescaler counter; must satisfy CLK_DIV <= 2^DIV_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
ena  in  1  count enable; prescaler advances only when high
mode24  in  1  display mode: 1 = 24-hour, 0 = 12-hour with pm
load  in  1  single-cycle time-load strobe
load_hh  in  8  BCD hour to load, always 24-hour format (00..23)
load_mm  in  8  BCD minute to load (00..59)
load_ss  in  8  BCD second to load (00..59)
load_err  out  1  one-cycle pulse: load rejected
sec_tick  out  1  one-cycle pulse on the cycle the seconds counter advances
pm  out  1  high when internal hour >= 12, in both modes
hh  out  8  BCD hour: 12-hour mode 01..12, 24-hour mode 00..23
mm  out  8  BCD minutes 00..59
ss  out  8  BCD seconds 00..59

Behaviour:
- Internal state is registered: hour24 (BCD 00..23), mm, ss, prescaler div_cnt.
- hh and pm are combinational from hour24 and mode24. A mode change is visible in the same cycle and does not alter the state.
- 12-hour map: 00->12 with pm=0; 01..11 -> same, pm=0; 12->12, pm=1; 13..23 -> 01..11, pm=1.
- Reset (reset==0 at posedge): hour24=00, mm=00, ss=00, div_cnt=0, sec_tick=0, load_err=0.
  - Visible result: 12:00:00 with pm=0 in 12-hour mode; 00:00:00 in 24-hour mode.
  - Reset has priority over load and ena.
- Prescaler: when ena=1 and no load, div_cnt increments. When div_cnt==CLK_DIV-1 and ena=1, div_cnt wraps to 0 and a second tick occurs.
  - sec_tick is registered: high the cycle after that edge, coinciding with the new ss.
  - ena=0 freezes div_cnt and the time.
- Second tick, BCD increment with carries:
  - ss 59->00 carries to mm; mm 59->00 carries to hour24; hour24 23->00.
  - Low nibble wraps 9->0 and carries to the high nibble.
  - 23:59:59 -> 00:00:00 in one tick.
- Load (load=1): takes priority over a tick in the same cycle.
  - Valid load: every nibble is <=9, load_hh<=0x23, load_mm<=0x59, load_ss<=0x59. State takes the loaded values at the next edge and div_cnt clears to 0. A tick falling in that cycle is discarded.
  - Invalid load: state and div_cnt are unchanged and load_err pulses high for one cycle.
- Non-BCD state is unreachable. The outputs never show an illegal code.

Optional Feature:
Macro ALARM_EN.
- When defined, the block adds these ports:
  - alarm_set in 1
  - alarm_hh in 8 (24-hour BCD)
  - alarm_mm in 8
  - alarm_clr in 1
  - alarm out 1
- alarm_set latches the alarm time, with the same validity rules as load; an invalid value is ignored and load_err pulses.
- Alarm registers reset to 00:00 with the alarm disarmed. alarm_set arms the alarm.
- alarm rises on the cycle the time becomes alarm_hh:alarm_mm:00, whether by tick or by load.
- alarm stays high until alarm_clr, reset, or 60 seconds later (the next minute rollover), whichever is first. alarm_clr wins over a simultaneous match.
- When not defined, none of these ports or registers exist.

Test Plan:
1. Reset low 2 cycles, mode24=0 -> hh=0x12, mm=0x00, ss=0x00, pm=0. Set mode24=1 -> hh=0x00 in the same cycle.
2. CLK_DIV=4, ena=1 -> sec_tick every 4th cycle and ss steps 00,01,02. ena low for 10 cycles -> no change. Re-raise ena -> count resumes from the frozen div_cnt.
3. Load 11:59:59, mode24=0, one tick -> hh=0x12, mm=0x00, ss=0x00, pm=1. Load 23:59:59, one tick -> hh=0x12, pm=0 (12-hour mode) or hh=0x00 (24-hour mode).
4. Load hh=0x24, and separately mm=0x5A -> load_err pulses one cycle and the time is unchanged. Load 13:05:09 valid -> mode24=0 shows 01:05:09 with pm=1.
5. Load asserted on the exact tick cycle with value 08:00:00 -> the time is 08:00:00 (the tick is discarded) and the next tick comes CLK_DIV cycles later.
6. ALARM_EN defined: alarm 07:30, load 07:29:59, one tick -> alarm=1. alarm_clr -> alarm=0. Repeat without clr -> alarm stays high until 07:31:00.
